// File: rtl/uart_tx_core.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Ports: i_clk/i_rst, i_parallel_data/i_data_valid/i_parity_en/i_parity_type in, o_tx_out/o_busy out.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_parallel_data,
  input  logic                  i_data_valid,
  input  logic                  i_parity_en,
  input  logic                  i_parity_type,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  r_pen;
  logic                  w_pen_nxt;
  logic                  r_ptype;
  logic                  w_ptype_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_pen   <= 1'b0;
      r_ptype <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_pen   <= w_pen_nxt;
      r_ptype <= w_ptype_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_pen_nxt   = r_pen;
    w_ptype_nxt = r_ptype;
    unique case (r_state)
      IDLE: begin
        if (i_data_valid) begin
          w_state_nxt = START;
          w_data_nxt  = i_parallel_data;
          w_pen_nxt   = i_parity_en;
          w_ptype_nxt = i_parity_type;
        end
      end
      START: begin
        w_state_nxt = DATA;
        w_cnt_nxt   = '0;
      end
      DATA: begin
        if (r_cnt == LAST) begin
          w_state_nxt = r_pen ? PARITY : STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PARITY: w_state_nxt = STOP;
      STOP:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level is decoded from the upcoming state so the pin
  // comes straight from a flop and changes only on the clock edge.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = (w_state_nxt != IDLE);
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_data_nxt[w_cnt_nxt];
      PARITY:  w_tx_nxt = (^w_data_nxt) ^ w_ptype_nxt;
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign o_tx_out = r_tx;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_core.sv
// Randomized and directed bench for uart_tx_core.
// A frame-queue reference model predicts the line and busy every cycle.
module tb_uart_tx_core;

  logic       clk;
  logic       rst;
  logic [7:0] pdata;
  logic       dvalid;
  logic       pen;
  logic       ptype;
  logic       tx_out;
  logic       busy;

  int n_cmp;
  int n_err;

  bit   exp_tx;
  bit   exp_busy;
  bit   q[$];

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_parallel_data(pdata),
    .i_data_valid   (dvalid),
    .i_parity_en    (pen),
    .i_parity_type  (ptype),
    .o_tx_out       (tx_out),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a request accepted while the line is idle queues the whole
  // frame's bit levels; each cycle pops one, empty queue means idle.
  task automatic model_edge(input bit r, input bit v, input bit [7:0] d,
                            input bit pe, input bit pt);
    if (r) begin
      q.delete();
    end else if (!exp_busy && v) begin
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
      if (pe) q.push_back((^d) ^ pt);
      q.push_back(1'b1);
    end
    if (!r && q.size() > 0) begin
      exp_tx   = q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
  endtask

  task automatic step(input string tag, input bit r, input bit v,
                      input bit [7:0] d, input bit pe, input bit pt);
    rst    = r;
    dvalid = v;
    pdata  = d;
    pen    = pe;
    ptype  = pt;
    @(posedge clk);
    model_edge(r, v, d, pe, pt);
    #1;
    chk({tag, ".tx"}, tx_out, exp_tx);
    chk({tag, ".busy"}, busy, exp_busy);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 8'h00, 0, 0);
  endtask

  // Captures one frame from the line with constant expectations.
  task automatic frame(input string tag, input bit [7:0] d, input bit pe,
                       input bit pt, input bit [10:0] bits, input int len);
    step({tag, ".b0"}, 0, 1, d, pe, pt);
    chk({tag, ".lit0"}, tx_out, bits[len-1]);
    for (int i = 1; i < len; i++) begin
      step({tag, ".bn"}, 0, 0, ~d, ~pe, ~pt);
      chk({tag, ".lit"}, tx_out, bits[len-1-i]);
      chk({tag, ".litbusy"}, busy, 1'b1);
    end
    step({tag, ".end"}, 0, 0, d, pe, pt);
    chk({tag, ".endbusy"}, busy, 1'b0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    exp_tx   = 1'b1;
    exp_busy = 1'b0;
    rst = 1; dvalid = 0; pdata = 0; pen = 0; ptype = 0;

    step("reset", 1, 0, 8'h00, 0, 0);
    chk("reset.tx_lit", tx_out, 1'b1);
    chk("reset.busy_lit", busy, 1'b0);
    idle("idle", 2);

    frame("np_aa", 8'hAA, 0, 0, 11'b00010101011, 10);
    frame("even_aa", 8'hAA, 1, 0, 11'b00101010101, 11);
    frame("odd_aa", 8'hAA, 1, 1, 11'b00101010111, 11);

    // Mid-frame request with new data must not disturb the frame.
    step("mid.start", 0, 1, 8'hAA, 0, 0);
    for (int i = 1; i < 10; i++) begin
      if (i == 4) step("mid.req", 0, 1, 8'hE4, 1, 1);
      else step("mid.run", 0, 0, 8'hE4, 0, 0);
    end
    idle("mid.after", 3);

    // Back to back: 0xAA plain, then 0xEC even parity.
    frame("b2b_aa", 8'hAA, 0, 0, 11'b00010101011, 10);
    frame("b2b_ec", 8'hEC, 1, 0, 11'b00011011111, 11);

    // Held request: frames restart after one idle cycle.
    for (int i = 0; i < 25; i++) step("held", 0, 1, 8'h5C, 1, 1);
    idle("held.after", 12);

    // Reset in the middle of the data bits.
    step("rmid.start", 0, 1, 8'h3B, 1, 0);
    idle("rmid.data", 4);
    step("rmid.rst", 1, 0, 8'h00, 0, 0);
    chk("rmid.tx_lit", tx_out, 1'b1);
    chk("rmid.busy_lit", busy, 1'b0);
    idle("rmid.after", 2);

    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0), 8'($urandom),
           1'($urandom), 1'($urandom));
    end
    idle("final", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- UART transmitter top level: serializes one 8-bit parallel word per request into a standard asynchronous frame on a single line.
- Frame: start bit, 8 data bits LSB first, optional parity bit, stop bit; one bit per CLK cycle (CLK is the baud clock).
- Sits between a byte-producing host and the serial TX pin.
- Internally: FSM, serializer, parity calculator, output mux.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; all behaviour below assumes 8.

Ports:
- CLK  input  1  baud-rate clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- Parallel_data  input  8  word to transmit; sampled only when a request is accepted.
- data_valid  input  1  transmit request; sampled on a CLK rising edge.
- parity_EN  input  1  1 = insert a parity bit; sampled with the data.
- parity_type  input  1  0 = even, 1 = odd; sampled with the data.
- TX_OUT  output  1  serial line; idle/mark level is 1.
- busy  output  1  high while a frame is on the line.

Behaviour:
- Reset:
  - RST=1 at a rising edge forces state IDLE, TX_OUT=1, busy=0, and clears internal registers.
  - Overrides everything, including a frame in progress; the frame is aborted with no stop bit.
- All outputs are registered and glitch-free.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If data_valid=1 at a rising edge: latch Parallel_data, parity_EN and parity_type into internal registers and go to START.
  - Otherwise stay in IDLE.
- START: TX_OUT=0, busy=1; one cycle, then DATA with bit counter=0.
- DATA:
  - TX_OUT = latched_data[counter], busy=1; counter increments each cycle.
  - After bit 7, go to PARITY if latched parity_EN=1, else STOP.
- PARITY:
  - TX_OUT = XOR of the 8 latched bits when even; its inverse when odd. busy=1.
  - One cycle, then STOP.
- STOP: TX_OUT=1, busy=1; one cycle, then IDLE.
- Latency: the start bit appears on TX_OUT in the cycle immediately after the edge that sampled data_valid=1. busy rises on that same edge.
- Frame length: 10 cycles without parity, 11 with parity. busy is high for exactly that many cycles.
- data_valid is a level: if it is still high on the first IDLE edge after STOP, a new frame starts immediately. A single-cycle pulse gives exactly one frame.
- Requests while busy=1 are ignored and not queued.
- Changes to Parallel_data, parity_EN or parity_type while busy=1 do not affect the current frame.
- Parity is computed from the latched data only, never from live inputs.

Test Plan:
- Reset: RST=1 for one edge, then RST=0 with data_valid=0 → TX_OUT=1, busy=0. Holding data_valid=0 for 2 cycles keeps TX_OUT=1, busy=0.
- No parity, 0xAA, one-cycle data_valid pulse:
  - TX_OUT over 10 cycles = 0,0,1,0,1,0,1,0,1,1; busy=1 for exactly those 10 cycles.
  - Then TX_OUT=1, busy=0.
- Even parity, 0xAA: TX_OUT = 0,0,1,0,1,0,1,0,1,0(parity),1; busy high for 11 cycles.
- Odd parity, 0xAA: same sequence but parity bit=1; busy high for 11 cycles.
- Mid-frame changes, 0xAA no parity: change Parallel_data to 0xE4 and assert data_valid in cycle 5 of the frame.
  - Frame still carries 0xAA bits.
  - No second frame starts unless data_valid is high in IDLE.
- Back-to-back frames:
  - Send 0xAA no parity; after return to IDLE, send 0xEC with even parity.
  - Second frame TX_OUT = 0,0,0,1,1,0,1,1,1,1(parity),1.
- Reset mid-frame: assert RST during DATA → next edge TX_OUT=1, busy=0, state IDLE.
